// File: rtl/trigger_conditioner_if.sv
// Trigger conditioner bus: control and raw trigger in, conditioned pulse and status out.
interface trigger_conditioner_if #(
  parameter int unsigned CNT_W = 16
);
  logic             ext_trig;
  logic [1:0]       mode;
  logic             enable;
  logic             cnt_clr;
  logic             pulse;
  logic             trig_src;
  logic             trig_lost;
  logic [CNT_W-1:0] trig_count;

  modport master (
    output ext_trig, mode, enable, cnt_clr,
    input  pulse, trig_src, trig_lost, trig_count
  );

  modport slave (
    input  ext_trig, mode, enable, cnt_clr,
    output pulse, trig_src, trig_lost, trig_count
  );
endinterface

// File: rtl/trigger_conditioner.sv
// Trigger front end: sync, glitch filter and holdoff on the external trigger, internal period
// generator with auto-mode fallback; emits one-cycle pulses and counts them.
module trigger_conditioner #(
  parameter int unsigned FILT_LEN   = 3,
  parameter int unsigned HOLDOFF    = 1000,
  parameter int unsigned INT_PERIOD = 6250,
  parameter int unsigned TIMEOUT    = 12500,
  parameter int unsigned CNT_W      = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  trigger_conditioner_if.slave bus
);
  localparam int unsigned FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned HW = $clog2(HOLDOFF + 1);
  localparam int unsigned PW = (INT_PERIOD > 1) ? $clog2(INT_PERIOD) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ModeInt  = 2'b01;
  localparam logic [1:0] ModeAuto = 2'b10;
  localparam logic [1:0] ModeOff  = 2'b11;

  typedef enum logic [1:0] {StIdle, StRunExt, StRunInt, StFallback} state_e;

  state_e           state_q;
  logic [1:0]       run_mode_q;
  logic             sync1_q, sync2_q, filt_q;
  logic [FW-1:0]    filt_cnt_q;
  logic [HW-1:0]    hold_q;
  logic [PW-1:0]    per_q;
  logic [TW-1:0]    to_q;
  logic             pulse_q, src_q, lost_q;
  logic [CNT_W-1:0] count_q;

  logic filt_flip, ext_rise, ext_ok, int_tc, leave, fire, fire_int;

  // The filtered level flips on the FILT_LEN-th consecutive differing sample.
  assign filt_flip = (sync2_q != filt_q) && (filt_cnt_q == FW'(FILT_LEN - 1));
  assign ext_rise  = filt_flip && sync2_q;
  assign ext_ok    = ext_rise && (hold_q == '0);
  assign int_tc    = (per_q == PW'(INT_PERIOD - 1));
  assign leave     = !bus.enable || (bus.mode != run_mode_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      sync1_q <= bus.ext_trig;
      sync2_q <= sync1_q;
      if (sync2_q == filt_q || filt_flip) filt_cnt_q <= '0;
      else                                filt_cnt_q <= filt_cnt_q + FW'(1);
      if (filt_flip) filt_q <= sync2_q;
    end
  end

  always_comb begin
    fire     = 1'b0;
    fire_int = 1'b0;
    if (!leave) begin
      unique case (state_q)
        StRunExt:   fire = ext_ok;
        StRunInt:   begin fire = int_tc; fire_int = 1'b1; end
        // A coincident external edge wins and is reported as external.
        StFallback: begin fire = ext_ok || int_tc; fire_int = !ext_ok; end
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      run_mode_q <= 2'b00;
      hold_q     <= '0;
      per_q      <= '0;
      to_q       <= '0;
      pulse_q    <= 1'b0;
      src_q      <= 1'b0;
      lost_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      pulse_q <= fire;
      if (fire) src_q <= fire_int;
      if (bus.cnt_clr) count_q <= '0;
      else if (fire)   count_q <= count_q + CNT_W'(1);
      if (hold_q != '0) hold_q <= hold_q - HW'(1);

      if (state_q == StIdle || leave) begin
        hold_q <= '0;
        per_q  <= '0;
        to_q   <= '0;
        lost_q <= 1'b0;
        if (state_q != StIdle) begin
          state_q <= StIdle;
        end else if (bus.enable && bus.mode != ModeOff) begin
          run_mode_q <= bus.mode;
          state_q    <= (bus.mode == ModeInt) ? StRunInt : StRunExt;
        end
      end else begin
        unique case (state_q)
          StRunExt: begin
            if (ext_ok) begin
              hold_q <= HW'(HOLDOFF);
              to_q   <= '0;
            end else if (run_mode_q == ModeAuto) begin
              if (to_q == TW'(TIMEOUT - 1)) begin
                state_q <= StFallback;
                lost_q  <= 1'b1;
                per_q   <= '0;
                to_q    <= '0;
              end else begin
                to_q <= to_q + TW'(1);
              end
            end
          end
          StRunInt: per_q <= int_tc ? '0 : per_q + PW'(1);
          StFallback: begin
            if (ext_ok) begin
              state_q <= StRunExt;
              lost_q  <= 1'b0;
              to_q    <= '0;
              hold_q  <= HW'(HOLDOFF);
            end else begin
              per_q <= int_tc ? '0 : per_q + PW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.pulse      = pulse_q;
  assign bus.trig_src   = src_q;
  assign bus.trig_lost  = lost_q;
  assign bus.trig_count = count_q;
endmodule

// File: tb/tb_trigger_conditioner.sv
// Randomised and directed bench for trigger_conditioner against a time-based reference model.
module tb_trigger_conditioner;
  localparam int unsigned FILT_LEN   = 3;
  localparam int unsigned HOLDOFF    = 100;
  localparam int unsigned INT_PERIOD = 60;
  localparam int unsigned TIMEOUT    = 250;
  localparam int unsigned CNT_W      = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trigger_conditioner_if #(.CNT_W(CNT_W)) bus ();

  trigger_conditioner #(
    .FILT_LEN  (FILT_LEN),
    .HOLDOFF   (HOLDOFF),
    .INT_PERIOD(INT_PERIOD),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: timing expressed as elapsed cycles since reference events.
  bit               m_d1, m_d2, m_run_val, m_filt;
  int               m_run_len;
  bit               m_active, m_lost, m_pulse, m_src;
  logic [1:0]       m_mode;
  int               m_start, m_ref, m_last_acc, cyc;
  logic [CNT_W-1:0] m_count;

  task automatic model_reset();
    m_d1 = 0; m_d2 = 0; m_run_val = 0; m_run_len = 0; m_filt = 1;
    m_active = 0; m_lost = 0; m_pulse = 0; m_src = 0; m_mode = 0;
    m_start = 0; m_ref = 0; m_last_acc = -1; m_count = '0;
  endtask

  task automatic model_step();
    bit samp, rise, ext_ok, int_p, fire, src_int;
    samp = m_d2;
    m_d2 = m_d1;
    m_d1 = bus.ext_trig;
    if (samp == m_run_val) m_run_len++;
    else begin m_run_val = samp; m_run_len = 1; end
    rise = 0;
    if (m_run_len >= int'(FILT_LEN) && m_filt != m_run_val) begin
      rise   = m_run_val;
      m_filt = m_run_val;
    end
    cyc++;
    fire = 0;
    src_int = 0;
    if (!m_active) begin
      if (bus.enable && bus.mode != 2'b11) begin
        m_active = 1; m_mode = bus.mode; m_start = cyc; m_ref = cyc;
        m_lost = 0; m_last_acc = -1;
      end
    end else if (!bus.enable || bus.mode != m_mode) begin
      m_active = 0;
      m_lost = 0;
    end else begin
      ext_ok = rise && (m_last_acc < 0 || cyc - m_last_acc > int'(HOLDOFF));
      int_p  = (cyc > m_start) && ((cyc - m_start) % int'(INT_PERIOD) == 0);
      if (m_mode == 2'b01) begin
        fire = int_p; src_int = 1;
      end else if (ext_ok) begin
        fire = 1; m_last_acc = cyc; m_ref = cyc; m_lost = 0;
      end else if (m_lost) begin
        fire = int_p; src_int = 1;
      end else if (m_mode == 2'b10 && cyc - m_ref == int'(TIMEOUT)) begin
        m_lost = 1; m_start = cyc;
      end
    end
    if (fire) m_src = src_int;
    if (bus.cnt_clr) m_count = '0;
    else if (fire)   m_count = m_count + 1'b1;
    m_pulse = fire;
  endtask

  int tcount = 0;
  int npulse = 0;
  int last_pulse_tick = 0;

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    tcount++;
    if (bus.pulse) begin npulse++; last_pulse_tick = tcount; end
    check("outs", {bus.pulse, bus.trig_src, bus.trig_lost, bus.trig_count},
          {m_pulse, m_src, m_lost, m_count});
  endtask

  task automatic wait_pulse(input int max_t, output int n);
    n = 0;
    do begin tick(); n++; end while (!bus.pulse && n < max_t);
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  int n, t0, run_left, r;

  initial begin
    bus.ext_trig = 1'b1; bus.mode = 2'b00; bus.enable = 1'b1; bus.cnt_clr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_outs", {bus.pulse, bus.trig_src, bus.trig_lost, bus.trig_count}, 0);
    rst_n = 1'b1;

    // Trigger held high through reset release must not fire.
    ticks(20);
    check("hold_thru_rst", npulse, 0);

    bus.ext_trig = 1'b0; ticks(5);
    npulse = 0;
    bus.ext_trig = 1'b1;
    wait_pulse(50, n);
    check("ext_latency", n, FILT_LEN + 2);
    ticks(20 - n);
    check("ext_npulse", npulse, 1);
    check("ext_count", bus.trig_count, 1);
    check("ext_src", bus.trig_src, 0);

    // Glitch shorter than the filter.
    bus.ext_trig = 1'b0; ticks(120);
    bus.ext_trig = 1'b1; ticks(2);
    bus.ext_trig = 1'b0; ticks(20);
    check("glitch_count", bus.trig_count, 1);

    // Second edge inside holdoff is dropped.
    bus.ext_trig = 1'b1; ticks(10);
    check("post_glitch_count", bus.trig_count, 2);
    bus.ext_trig = 1'b0; ticks(30);
    bus.ext_trig = 1'b1; ticks(10);
    check("holdoff_drop", bus.trig_count, 2);
    bus.ext_trig = 1'b0; ticks(120);

    // Internal mode: first pulse INT_PERIOD after entry (one cycle via IDLE).
    bus.mode = 2'b01; bus.cnt_clr = 1'b1; tick(); bus.cnt_clr = 1'b0;
    wait_pulse(1000, n);
    check("int_first", n + 1, INT_PERIOD + 2);
    for (int i = 0; i < 3; i++) begin
      wait_pulse(1000, n);
      check("int_period", n, INT_PERIOD);
    end
    check("int_count4", bus.trig_count, 4);
    check("int_src", bus.trig_src, 1);

    for (int i = 0; i < 12; i++) wait_pulse(1000, n);
    check("wrap", bus.trig_count, 0);

    // cnt_clr on the very cycle of a pulse.
    ticks(INT_PERIOD - 1);
    bus.cnt_clr = 1'b1; tick(); bus.cnt_clr = 1'b0;
    check("clr_pulse", bus.pulse, 1);
    check("clr_prio", bus.trig_count, 0);
    wait_pulse(1000, n);
    check("after_clr", bus.trig_count, 1);

    // Auto mode: external train, then loss and fallback, then recovery.
    bus.mode = 2'b10;
    for (int i = 0; i < 4; i++) begin
      bus.ext_trig = 1'b1; ticks(10);
      bus.ext_trig = 1'b0; ticks(110);
    end
    check("auto_not_lost", bus.trig_lost, 0);
    n = 0;
    while (!bus.trig_lost && n < 1000) begin tick(); n++; end
    check("lost_time", tcount - last_pulse_tick, TIMEOUT);
    t0 = tcount;
    wait_pulse(1000, n);
    check("fb_int", tcount - t0, INT_PERIOD);
    check("fb_src", bus.trig_src, 1);
    bus.ext_trig = 1'b1;
    wait_pulse(1000, n);
    check("recover_lat", n, FILT_LEN + 2);
    check("recover_lost", bus.trig_lost, 0);
    check("recover_src", bus.trig_src, 0);
    ticks(5);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {bus.pulse, bus.trig_src, bus.trig_lost, bus.trig_count}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random stimulus checked cycle by cycle against the model.
    bus.mode = 2'b10;
    run_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        bus.ext_trig = ~bus.ext_trig;
        r = int'($urandom_range(0, 9));
        if (r < 4)      run_left = int'($urandom_range(1, 4));
        else if (r < 9) run_left = int'($urandom_range(5, 130));
        else            run_left = int'($urandom_range(250, 400));
      end
      run_left--;
      if ($urandom_range(0, 399) == 0) bus.mode = 2'($urandom_range(0, 3));
      if (!bus.enable) bus.enable = ($urandom_range(0, 9) == 0);
      else if ($urandom_range(0, 599) == 0) bus.enable = 1'b0;
      bus.cnt_clr = ($urandom_range(0, 149) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
